// File: rtl/systolic_ctrl_if.sv
// Job-control and streaming bus between a sequencer master and the systolic controller.
interface systolic_ctrl_if #(
  parameter int unsigned N   = 3,
  parameter int unsigned K_W = 8
);
  logic           start;
  logic [K_W-1:0] k_len;
  logic           abort;
  logic           busy;
  logic           done;
  logic           clear;
  logic           a_rd_en;
  logic [K_W-1:0] a_rd_addr;
  logic [N-1:0]   valid_row;
  logic [31:0]    perf_cycles;

  modport master (
    output start, k_len, abort,
    input  busy, done, clear, a_rd_en, a_rd_addr, valid_row, perf_cycles
  );

  modport slave (
    input  start, k_len, abort,
    output busy, done, clear, a_rd_en, a_rd_addr, valid_row, perf_cycles
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N-row systolic MAC array: clear, stream K activations, drain, done.
// Optional busy-cycle performance counter enabled by SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
  parameter int unsigned N   = 3,
  parameter int unsigned K_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  systolic_ctrl_if.slave  bus
);

  localparam int unsigned D_W = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [K_W-1:0] k_len_q, k_len_d;
  logic [K_W-1:0] k_cnt_q, k_cnt_d;
  logic [D_W-1:0] drain_q, drain_d;
  logic [N-1:0]   vrow_q, vrow_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           clear_q, clear_d;
  logic           rd_en_q, rd_en_d;
  logic [K_W-1:0] addr_q, addr_d;
  logic           kill_c;

  assign kill_c = bus.abort && (state_q != S_IDLE);

  // Next-state and job counters
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    k_cnt_d = k_cnt_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.k_len != '0) begin
            k_len_d = bus.k_len;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        k_cnt_d = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        k_cnt_d = k_cnt_q + K_W'(1);
        if (k_cnt_q == k_len_q - K_W'(1)) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == D_W'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + D_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (kill_c) begin
      state_d = S_IDLE;
      k_cnt_d = '0;
      drain_d = '0;
    end
  end

  // Outputs are registered from the next state so they align with the state they describe
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    clear_d   = (state_d == S_CLEAR);
    rd_en_d   = (state_d == S_STREAM);
    addr_d    = rd_en_d ? k_cnt_d : '0;
    vrow_d    = '0;
    vrow_d[0] = (state_d == S_STREAM);
    for (int i = 1; i < int'(N); i++) begin
      vrow_d[i] = vrow_q[i-1];
    end
    if (kill_c) begin
      vrow_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      k_cnt_q <= '0;
      drain_q <= '0;
      vrow_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      k_cnt_q <= k_cnt_d;
      drain_q <= drain_d;
      vrow_q  <= vrow_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clear_q <= clear_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.clear     = clear_q;
  assign bus.a_rd_en   = rd_en_q;
  assign bus.a_rd_addr = addr_q;
  assign bus.valid_row = vrow_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] perf_q, perf_d;

  // Counter value includes the upcoming busy cycle, so the DONE cycle is counted
  always_comb begin
    cnt_d  = cnt_q;
    perf_d = perf_q;
    if (state_d != S_IDLE) begin
      if (state_q == S_IDLE) begin
        cnt_d = 32'd1;
      end else if (cnt_q != 32'hFFFF_FFFF) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    if (state_d == S_DONE) begin
      perf_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Table-driven bench for systolic_ctrl with a done/perf scoreboard.
module tb_systolic_ctrl;

  localparam int unsigned N       = 3;
  localparam int unsigned K_W     = 8;
  localparam int          TBL_MAX = 300;

  typedef struct packed {
    logic           rst;
    logic           start;
    logic           abort;
    logic [K_W-1:0] k_len;
    logic           busy;
    logic           done;
    logic           clear;
    logic           rd_en;
    logic [K_W-1:0] addr;
    logic [N-1:0]   vrow;
  } vec_t;

  logic clk;
  logic rst;

  systolic_ctrl_if #(.N(N), .K_W(K_W)) bus ();

  systolic_ctrl #(.N(N), .K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t        tbl [TBL_MAX];
  int          tbl_len;
  int unsigned sb_q [$];
  int unsigned last_perf;
  int          n_chk;
  int          n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned exp_perf(input int k);
`ifdef SYSTOLIC_CTRL_PERF_EN
    return (k == 0) ? 1 : k + N + 2;
`else
    return 0;
`endif
  endfunction

  function automatic void tbl_init(input int len);
    tbl_len = len;
    for (int c = 0; c < TBL_MAX; c++) tbl[c] = '0;
  endfunction

  // Expected outputs of an uninterrupted job whose start is driven in cycle s
  function automatic void add_job(input int s, input int k, input bit push);
    if (k == 0) begin
      tbl[s+1].busy = 1'b1;
      tbl[s+1].done = 1'b1;
    end else begin
      for (int r = 1; r <= k + N + 2; r++) begin
        int c;
        c = s + r;
        if (c < TBL_MAX) begin
          tbl[c].busy = 1'b1;
          if (r == 1) tbl[c].clear = 1'b1;
          if (r >= 2 && r <= k + 1) begin
            tbl[c].rd_en = 1'b1;
            tbl[c].addr  = K_W'(r - 2);
          end
          if (r == k + N + 2) tbl[c].done = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (r - i >= 2 && r - i <= k + 1) tbl[c].vrow[i] = 1'b1;
          end
        end
      end
    end
    if (push) begin
      sb_q.push_back(exp_perf(k));
      last_perf = exp_perf(k);
    end
  endfunction

  // Everything from cycle 'from' onward is expected idle
  function automatic void cut(input int from);
    for (int c = from; c < TBL_MAX; c++) begin
      tbl[c].busy  = 1'b0;
      tbl[c].done  = 1'b0;
      tbl[c].clear = 1'b0;
      tbl[c].rd_en = 1'b0;
      tbl[c].addr  = '0;
      tbl[c].vrow  = '0;
    end
  endfunction

  task automatic run_table(input string nm);
    for (int c = 0; c < tbl_len; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s c%0d {busy,done,clr,rd,addr,vrow}", nm, c),
            32'({bus.busy, bus.done, bus.clear, bus.a_rd_en, bus.a_rd_addr, bus.valid_row}),
            32'({tbl[c].busy, tbl[c].done, tbl[c].clear, tbl[c].rd_en, tbl[c].addr, tbl[c].vrow}));
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s c%0d unexpected done: got done=1, want no pending job", nm, c);
        end else begin
          check($sformatf("%s c%0d perf_cycles", nm, c), bus.perf_cycles, sb_q.pop_front());
        end
      end
      rst       = tbl[c].rst;
      bus.start = tbl[c].start;
      bus.abort = tbl[c].abort;
      bus.k_len = tbl[c].k_len;
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.k_len = '0;
    check($sformatf("%s scoreboard drained", nm), 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    last_perf = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.k_len = K_W'(4);
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({bus.busy, bus.done, bus.clear, bus.a_rd_en, bus.a_rd_addr, bus.valid_row}), 32'd0);
    check("reset perf", bus.perf_cycles, 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.k_len = '0;

    // Basic k_len=4 job
    tbl_init(12);
    tbl[0].start = 1'b1;
    tbl[0].k_len = K_W'(4);
    add_job(0, 4, 1'b1);
    run_table("k4");

    // Zero-length job goes straight to DONE
    tbl_init(4);
    tbl[0].start = 1'b1;
    add_job(0, 0, 1'b1);
    run_table("k0");

    // abort with start in IDLE: nothing happens
    tbl_init(4);
    tbl[0].start = 1'b1;
    tbl[0].abort = 1'b1;
    tbl[0].k_len = K_W'(4);
    run_table("abort_idle");

    // Abort mid-stream, perf_cycles keeps the previous job's count
    tbl_init(8);
    tbl[0].start = 1'b1;
    tbl[0].k_len = K_W'(4);
    add_job(0, 4, 1'b0);
    tbl[4].abort = 1'b1;
    cut(5);
    run_table("abort");
    check("perf after abort", bus.perf_cycles, last_perf);

    // Normal job after abort, with start re-pulsed while busy
    tbl_init(12);
    tbl[0].start = 1'b1;
    tbl[0].k_len = K_W'(4);
    tbl[3].start = 1'b1;
    tbl[3].k_len = K_W'(7);
    tbl[6].start = 1'b1;
    tbl[6].k_len = K_W'(0);
    add_job(0, 4, 1'b1);
    run_table("restart_ignored");

    // Reset mid-job
    tbl_init(10);
    tbl[0].start = 1'b1;
    tbl[0].k_len = K_W'(4);
    add_job(0, 4, 1'b0);
    tbl[5].rst = 1'b1;
    cut(6);
    run_table("rst_mid");
    check("perf after rst", bus.perf_cycles, 32'd0);
    last_perf = 0;

    // Back-to-back jobs with start held high
    tbl_init(18);
    for (int c = 0; c <= 8; c++) begin
      tbl[c].start = 1'b1;
      tbl[c].k_len = (c < 8) ? K_W'(2) : K_W'(1);
    end
    add_job(0, 2, 1'b1);
    add_job(8, 1, 1'b1);
    run_table("b2b");

    // Maximum length without counter wrap
    tbl_init(2 ** K_W - 1 + N + 5);
    tbl[0].start = 1'b1;
    tbl[0].k_len = '1;
    add_job(0, 2 ** K_W - 1, 1'b1);
    run_table("kmax");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
